seq_engine_sched: RTL

Round-robin scheduler that shares one serial Mealy sequence engine (`seq_circuit`-class, 1-bit input C, 1-bit output Y, states IDLE/S1/S2/S3) among NUM_REQ requesters. Each accepted job is a bit vector that the block serializes onto C, LSB first. It captures the engine's Y response bit-for-bit and returns it to the requester. A shadow model of the engine tracks its state so that the block can drive state-preserving idle values, optionally flush the engine to IDLE between jobs, and flag divergence.

---
 rtl/seq_engine_sched.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/seq_engine_sched.sv
// Round-robin scheduler sharing one serial Mealy sequence engine among NUM_REQ requesters.
// Define SEQ_SCHED_FLUSH_EN to return the engine to IDLE before every job.
//
// state    | meaning
// ST_IDLE  | engine parked on its self-loop value, waiting for a grant
// ST_FLUSH | walking the engine back to IDLE, Y ignored
// ST_RUN   | serializing job bits onto C, capturing Y
// ST_DONE  | one-cycle result strobe, no grant
module seq_engine_sched #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 16,
  parameter int LEN_W   = 5
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]    req_bits,
  input  logic [NUM_REQ*LEN_W-1:0]     req_len,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic                         eng_c,
  input  logic                         eng_y,
  output logic                         done_valid,
  output logic [$clog2(NUM_REQ)-1:0]   done_id,
  output logic [DATA_W-1:0]            done_data,
  output logic                         busy,
  output logic                         shadow_err
);

  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int ID_W1 = ID_W + 1;
  localparam int IDX_W = $clog2(DATA_W);
  localparam logic [ID_W:0]    REQ_CNT = ID_W1'(NUM_REQ);
  localparam logic [ID_W-1:0]  ID_LAST = ID_W'(NUM_REQ - 1);
  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(DATA_W);

`ifdef SEQ_SCHED_FLUSH_EN
  localparam bit FLUSH_EN = 1'b1;
`else
  localparam bit FLUSH_EN = 1'b0;
`endif

  typedef enum logic [1:0] {ST_IDLE, ST_FLUSH, ST_RUN, ST_DONE} st_t;
  typedef enum logic [1:0] {SH_IDLE, SH_S1, SH_S2, SH_S3} sh_t;

  st_t               st;
  sh_t               shadow;
  sh_t               sh_nxt;
  logic              pred_y;
  logic [ID_W-1:0]   rr_ptr;
  logic [ID_W-1:0]   id_q;
  logic [ID_W-1:0]   gnt_id;
  logic              gnt_any;
  logic [ID_W:0]     cand;
  logic [DATA_W-1:0] bits_q;
  logic [DATA_W-1:0] data_q;
  logic [DATA_W-1:0] sel_bits;
  logic [LEN_W-1:0]  sel_len;
  logic [LEN_W-1:0]  len_cl;
  logic [LEN_W-1:0]  rem;
  logic [IDX_W-1:0]  bit_idx;
  logic [IDX_W-1:0]  nxt_idx;

  function automatic sh_t sh_step(input sh_t s, input logic c);
    case (s)
      SH_IDLE: sh_step = c ? SH_S1 : SH_IDLE;
      SH_S1:   sh_step = c ? SH_S1 : SH_S3;
      SH_S3:   sh_step = c ? SH_S2 : SH_S3;
      default: sh_step = c ? SH_S2 : SH_IDLE;
    endcase
  endfunction

  // C value that keeps the engine in its current state; its inverse steps toward IDLE
  function automatic logic hold_c(input sh_t s);
    hold_c = (s == SH_S1) || (s == SH_S2);
  endfunction

  always_comb begin
    sh_nxt  = sh_step(shadow, eng_c);
    pred_y  = (shadow == SH_S3) || ((shadow == SH_S2) && eng_c);
    nxt_idx = bit_idx + 1'b1;
    gnt_any = 1'b0;
    gnt_id  = '0;
    cand    = '0;
    // walk downward so the smallest offset from rr_ptr wins
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      cand = {1'b0, rr_ptr} + ID_W1'(i);
      if (cand >= REQ_CNT) cand = cand - REQ_CNT;
      if (req_valid[cand[ID_W-1:0]]) begin
        gnt_any = 1'b1;
        gnt_id  = cand[ID_W-1:0];
      end
    end
    sel_bits = '0;
    sel_len  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_id == ID_W'(i)) begin
        sel_bits = req_bits[i*DATA_W +: DATA_W];
        sel_len  = req_len[i*LEN_W +: LEN_W];
      end
    end
    len_cl = (sel_len > LEN_MAX) ? LEN_MAX : sel_len;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st         <= ST_IDLE;
      shadow     <= SH_IDLE;
      rr_ptr     <= '0;
      id_q       <= '0;
      bits_q     <= '0;
      data_q     <= '0;
      rem        <= '0;
      bit_idx    <= '0;
      req_ready  <= '0;
      eng_c      <= 1'b0;
      done_valid <= 1'b0;
      done_id    <= '0;
      done_data  <= '0;
      busy       <= 1'b0;
      shadow_err <= 1'b0;
    end else begin
      shadow     <= sh_nxt;
      req_ready  <= '0;
      done_valid <= 1'b0;
      if (eng_y != pred_y) shadow_err <= 1'b1;
      case (st)
        ST_IDLE: begin
          eng_c <= hold_c(sh_nxt);
          if (gnt_any) begin
            req_ready <= NUM_REQ'(1) << gnt_id;
            id_q      <= gnt_id;
            bits_q    <= sel_bits;
            rem       <= len_cl;
            bit_idx   <= '0;
            data_q    <= '0;
            rr_ptr    <= (gnt_id == ID_LAST) ? '0 : gnt_id + 1'b1;
            busy      <= 1'b1;
            if (FLUSH_EN && (sh_nxt != SH_IDLE)) begin
              st    <= ST_FLUSH;
              eng_c <= ~hold_c(sh_nxt);
            end else if (len_cl != '0) begin
              st    <= ST_RUN;
              eng_c <= sel_bits[0];
            end else begin
              st         <= ST_DONE;
              done_valid <= 1'b1;
              done_id    <= gnt_id;
              done_data  <= '0;
            end
          end
        end
        ST_FLUSH: begin
          if (sh_nxt != SH_IDLE) begin
            eng_c <= ~hold_c(sh_nxt);
          end else if (rem != '0) begin
            st    <= ST_RUN;
            eng_c <= bits_q[0];
          end else begin
            st         <= ST_DONE;
            eng_c      <= hold_c(sh_nxt);
            done_valid <= 1'b1;
            done_id    <= id_q;
            done_data  <= '0;
          end
        end
        ST_RUN: begin
          data_q[bit_idx] <= eng_y;
          if (rem == LEN_W'(1)) begin
            st         <= ST_DONE;
            eng_c      <= hold_c(sh_nxt);
            done_valid <= 1'b1;
            done_id    <= id_q;
            done_data  <= data_q | (DATA_W'(eng_y) << bit_idx);
          end else begin
            rem     <= rem - 1'b1;
            bit_idx <= nxt_idx;
            eng_c   <= bits_q[nxt_idx];
          end
        end
        ST_DONE: begin
          st    <= ST_IDLE;
          busy  <= 1'b0;
          eng_c <= hold_c(sh_nxt);
        end
        default: st <= ST_IDLE;
      endcase
    end
  end

endmodule
